// File: rtl/regfile_debug_access.sv
// Debug-side initiator for the 32 x XLEN register file.
// Serves read-one, write-one and dump-all commands while the core is halted.
module regfile_debug_access #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_halted,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [4:0]      cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic [4:0]      rf_rs1,
  input  logic [XLEN-1:0] rf_rdata1,
  output logic            rf_en,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_addr,
  output logic            rsp_last,
  output logic            rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

  state_t     state;
  logic [1:0] op;
  logic [4:0] addr;
  logic [4:0] idx;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rf_rs1    = idx;

  // Command FSM; every register-file and response output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op       <= OP_READ;
      addr     <= '0;
      idx      <= '0;
      rf_en    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      rsp_data <= '0;
      rsp_addr <= '0;
      rsp_last <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      rf_en    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op   <= cmd_op;
            addr <= cmd_addr;
            if (!core_halted || cmd_op == OP_RSVD) begin
              rsp_data <= '0;
              rsp_addr <= cmd_addr;
              rsp_last <= 1'b1;
              rsp_err  <= 1'b1;
              state    <= RESP;
            end else if (cmd_op == OP_READ) begin
              idx   <= cmd_addr;
              state <= RD;
            end else if (cmd_op == OP_DUMP) begin
              idx   <= '0;
              state <= RD;
            end else begin
              // x0 is hardwired; suppress the strobe but still ack.
              rf_en    <= (cmd_addr != 5'd0);
              rf_rd    <= cmd_addr;
              rf_wdata <= cmd_wdata;
              state    <= WR;
            end
          end
        end
        RD: begin
          rsp_data <= rf_rdata1;
          rsp_addr <= idx;
          rsp_err  <= 1'b0;
          rsp_last <= (op != OP_DUMP) || (idx == LAST_IDX);
          state    <= RESP;
        end
        WR: begin
          rsp_data <= '0;
          rsp_addr <= addr;
          rsp_err  <= 1'b0;
          rsp_last <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            if (rsp_last) begin
              state <= IDLE;
            end else begin
              idx   <= idx + 5'd1;
              state <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_debug_access.sv
// Bench for regfile_debug_access with a behavioural register file.
// Directed vector table plus hand-written stall, dump and reset sequences.
module tb_regfile_debug_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_halted;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [4:0]  rf_rs1;
  logic [31:0] rf_rdata1;
  logic        rf_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_addr;
  logic        rsp_last;
  logic        rsp_err;

  logic [31:0] regs [32];
  logic        preload = 1'b0;
  int          en_total = 0;
  logic [4:0]  en_rd = '0;
  logic [31:0] en_wd = '0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        halted;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          en;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  regfile_debug_access dut (
    .clk         (clk),
    .rst         (rst),
    .core_halted (core_halted),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rf_rs1      (rf_rs1),
    .rf_rdata1   (rf_rdata1),
    .rf_en       (rf_en),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_addr    (rsp_addr),
    .rsp_last    (rsp_last),
    .rsp_err     (rsp_err)
  );

  assign rf_rdata1 = (rf_rs1 == 5'd0) ? 32'd0 : regs[rf_rs1];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i) * 32'h11111111;
    end else if (rf_en) begin
      regs[rf_rd] <= rf_wdata;
    end
    if (rf_en) begin
      en_total <= en_total + 1;
      en_rd    <= rf_rd;
      en_wd    <= rf_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_fields"},
        64'({rsp_last, rsp_err, rsp_addr, rsp_data}), 64'd0);
    chk({tag, "_rf_outputs"},
        64'({rf_en, rf_rs1, rf_rd, rf_wdata}), 64'd0);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int t;
    int en0;
    core_halted = v.halted;
    cmd_op      = v.op;
    cmd_addr    = v.addr;
    cmd_wdata   = v.wdata;
    cmd_valid   = 1'b1;
    rsp_ready   = 1'b1;
    en0         = en_total;
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 1;
    while (!rsp_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_latency"}, 64'(t), 64'(v.lat));
    chk({tag, "_data"}, 64'(rsp_data), 64'(v.data));
    chk({tag, "_addr_last_err"}, 64'({rsp_addr, rsp_last, rsp_err}),
        64'({v.addr, 1'b1, v.err}));
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, 64'({cmd_ready, rsp_valid}), 64'b10);
    chk({tag, "_rf_en_count"}, 64'(en_total - en0), 64'(v.en));
    if (v.en != 0)
      chk({tag, "_rf_write"}, 64'({en_rd, en_wd}), 64'({v.addr, v.wdata}));
  endtask

  initial begin
    int n;
    int cyc;
    int hs;
    int en0;
    int stable_bad;
    int rs1_bad;
    logic have;
    logic [37:0] saved;
    logic [31:0] expd;

    vecs[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 2, 1};
    vecs[1] = '{2'b00, 5'd5,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 2, 0};
    vecs[2] = '{2'b01, 5'd0,  32'h00001234, 1'b1, 32'h0,        1'b0, 2, 0};
    vecs[3] = '{2'b00, 5'd0,  32'h0,        1'b1, 32'h0,        1'b0, 2, 0};
    vecs[4] = '{2'b00, 5'd7,  32'h0,        1'b0, 32'h0,        1'b1, 1, 0};
    vecs[5] = '{2'b11, 5'd9,  32'hFFFFFFFF, 1'b1, 32'h0,        1'b1, 1, 0};
    vecs[6] = '{2'b01, 5'd31, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0, 2, 1};
    vecs[7] = '{2'b00, 5'd31, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0, 2, 0};
    vecs[8] = '{2'b00, 5'd7,  32'h0,        1'b1, 32'h77777777, 1'b0, 2, 0};
    vecs[9] = '{2'b00, 5'd9,  32'h0,        1'b1, 32'h99999999, 1'b0, 2, 0};

    rst         = 1'b1;
    core_halted = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 2'b00;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    rsp_ready   = 1'b0;
    preload     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;
    chk_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Stall in RESP with a second command already offered.
    en0         = en_total;
    core_halted = 1'b1;
    cmd_op      = 2'b00;
    cmd_addr    = 5'd31;
    cmd_valid   = 1'b1;
    rsp_ready   = 1'b0;
    @(posedge clk); #1;
    cmd_addr = 5'd2;
    @(posedge clk); #1;
    chk("stall_valid", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_hold%0d", i),
          64'({cmd_ready, rsp_valid, rsp_last, rsp_addr, rsp_data}),
          64'({1'b0, 1'b1, 1'b1, 5'd31, 32'hA5A5A5A5}));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_rsp", 64'({rsp_valid, rsp_addr, rsp_data}),
        64'({1'b1, 5'd2, 32'h22222222}));
    @(posedge clk); #1;
    chk("stall_no_rf_en", 64'(en_total - en0), 64'd0);

    // Dump with rsp_ready held high.
    preload = 1'b1;
    @(posedge clk); #1;
    preload   = 1'b0;
    cmd_op    = 2'b10;
    cmd_addr  = 5'd7;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0; cyc = 0; hs = 0;
    while (n < 32 && cyc < 200) begin
      if (rsp_valid) begin
        expd = 32'(n) * 32'h11111111;
        chk($sformatf("dump%0d", n),
            64'({rsp_err, rsp_last, rsp_addr, rsp_data}),
            64'({1'b0, n == 31, 5'(n), expd}));
        if (n == 31) hs = cyc + 1;
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("dump_count", 64'(n), 64'd32);
    chk("dump_cycles", 64'(hs), 64'd64);
    chk("dump_idle", 64'({cmd_ready, rsp_valid}), 64'b10);

    // Dump with random back-pressure.
    en0       = en_total;
    cmd_op    = 2'b10;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0; cyc = 0; stable_bad = 0; rs1_bad = 0; have = 1'b0;
    saved = '0;
    while (n < 32 && cyc < 2000) begin
      if (rf_rs1 != 5'(n)) rs1_bad++;
      rsp_ready = 1'($urandom_range(0, 1));
      if (rsp_valid) begin
        if (have && {rsp_last, rsp_addr, rsp_data} != saved) stable_bad++;
        if (rsp_ready) begin
          expd = 32'(n) * 32'h11111111;
          chk($sformatf("rdump%0d", n),
              64'({rsp_last, rsp_addr, rsp_data}),
              64'({n == 31, 5'(n), expd}));
          n++;
          have = 1'b0;
        end else begin
          have  = 1'b1;
          saved = {rsp_last, rsp_addr, rsp_data};
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    rsp_ready = 1'b1;
    chk("rdump_count", 64'(n), 64'd32);
    chk("rdump_stable", 64'(stable_bad), 64'd0);
    chk("rdump_rs1", 64'(rs1_bad), 64'd0);
    chk("rdump_no_rf_en", 64'(en_total - en0), 64'd0);

    // Reset in the middle of a dump.
    cmd_op    = 2'b10;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (rf_rs1 != 5'd10 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_dump_idx10", 64'(rf_rs1), 64'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset("mid_reset");
    run_cmd('{2'b00, 5'd3, 32'h0, 1'b1, 32'h33333333, 1'b0, 2, 0},
            "post_reset_rd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
